// File: rtl/iob_dual_bus_arbiter_if.sv
// IOb native bus bundle: request fields flow master -> slave, response fields slave -> master.
interface iob_dual_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ready;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/iob_dual_bus_arbiter.sv
// Two-to-one IOb arbiter (m0 = instruction, m1 = data) with one outstanding read.
// Define IOB_ARB_FIXED_PRIO_EN for fixed m1 priority instead of round-robin.
module iob_dual_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cke_i,
    iob_dual_bus_arbiter_if.slave  m0,
    iob_dual_bus_arbiter_if.slave  m1,
    iob_dual_bus_arbiter_if.master s
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_RD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              lock_q, lock_d;
    logic              lock_gnt_q, lock_gnt_d;
`ifndef IOB_ARB_FIXED_PRIO_EN
    logic              last_gnt_q, last_gnt_d;
`endif

    logic              gnt;
    logic              gnt_avalid;
    logic              s_avalid;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic [STRB_W-1:0] gnt_wstrb;

    // A stalled request keeps its grant until memory accepts it.
    always_comb begin
        gnt = 1'b0;
        if (lock_q) begin
            gnt = lock_gnt_q;
        end else if (m0.avalid && m1.avalid) begin
`ifdef IOB_ARB_FIXED_PRIO_EN
            gnt = 1'b1;
`else
            gnt = ~last_gnt_q;
`endif
        end else if (m1.avalid) begin
            gnt = 1'b1;
        end
    end

    always_comb begin
        gnt_avalid = gnt ? m1.avalid : m0.avalid;
        gnt_addr   = gnt ? m1.addr   : m0.addr;
        gnt_wdata  = gnt ? m1.wdata  : m0.wdata;
        gnt_wstrb  = gnt ? m1.wstrb  : m0.wstrb;
        s_avalid   = (state_q == IDLE) && gnt_avalid;
    end

    assign s.avalid  = s_avalid;
    assign s.addr    = gnt_addr;
    assign s.wdata   = gnt_wdata;
    assign s.wstrb   = gnt_wstrb;

    assign m0.ready  = s.ready && s_avalid && !gnt;
    assign m1.ready  = s.ready && s_avalid &&  gnt;

    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;
    assign m0.rvalid = (state_q == WAIT_RD) && s.rvalid && !owner_q;
    assign m1.rvalid = (state_q == WAIT_RD) && s.rvalid &&  owner_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lock_gnt_d = lock_gnt_q;
`ifndef IOB_ARB_FIXED_PRIO_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_avalid) begin
                    if (s.ready) begin
                        lock_d = 1'b0;
`ifndef IOB_ARB_FIXED_PRIO_EN
                        last_gnt_d = gnt;
`endif
                        // Only reads get a response; writes leave the port free.
                        if (gnt_wstrb == '0) begin
                            owner_d = gnt;
                            state_d = WAIT_RD;
                        end
                    end else begin
                        lock_d     = 1'b1;
                        lock_gnt_d = gnt;
                    end
                end
            end
            WAIT_RD: begin
                if (s.rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_gnt_q <= 1'b0;
`ifndef IOB_ARB_FIXED_PRIO_EN
            last_gnt_q <= 1'b1;
`endif
        end else if (cke_i) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
`ifndef IOB_ARB_FIXED_PRIO_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end
endmodule

// File: doc/iob_dual_bus_arbiter.md
# iob_dual_bus_arbiter

Two-to-one arbiter for IOb native buses. It merges the CPU instruction bus (m0) and data bus (m1) onto a single memory port (s), so a core with split buses can share one memory or cache. It allows at most one outstanding read, routes each read response back to the requester that issued it, and keeps writes as fire-and-forget.

## Interface
Parameters:
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width; wstrb width is DATA_W/8

Ports (x = 0 is the instruction requester, x = 1 is the data requester):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- cke_i  in  1  clock enable; when low, all state registers hold
- mx_avalid_i  in  1  request valid from requester x
- mx_addr_i  in  ADDR_W  request address
- mx_wdata_i  in  DATA_W  write data
- mx_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read
- mx_ready_o  out  1  request accepted this cycle
- mx_rdata_o  out  DATA_W  read data
- mx_rvalid_o  out  1  read data valid
- s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o  out  request to memory
- s_ready_i, s_rdata_i, s_rvalid_i  in  response from memory

## Operation
- FSM states:
  - IDLE: requests may issue.
  - WAIT_RD: one read is outstanding; issuing is blocked.
- Grant selection in IDLE, when the lock is clear:
  - Only one requester with avalid high: that requester wins.
  - Both high: round-robin. The requester not granted most recently wins.
  - Pointer last_gnt resets to 1, so m0 wins the first tie.
- s_* request fields are muxed from the granted requester.
- s_avalid_o = granted avalid, and only in IDLE. In WAIT_RD, s_avalid_o = 0.
- mx_ready_o = s_ready_i & s_avalid_o & (gnt == x). The non-granted requester sees ready = 0.
- Lock:
  - Set when s_avalid_o & ~s_ready_i.
  - While set, the grant is frozen on the same requester.
  - Cleared on acceptance (s_avalid_o & s_ready_i).
  - Requesters must hold avalid and request fields stable until ready.
- On acceptance:
  - last_gnt <= gnt.
  - If wstrb == 0 (read): owner <= gnt, state -> WAIT_RD.
  - If wstrb != 0 (write): stay in IDLE. Writes get no response.
- In WAIT_RD:
  - m[owner]_rvalid_o = s_rvalid_i. The other requester's rvalid_o = 0.
  - On s_rvalid_i: state -> IDLE.
- In IDLE, s_rvalid_i is ignored and both mx_rvalid_o = 0.
- mx_rdata_o = s_rdata_i for both requesters; only meaningful while that requester's rvalid_o is high.
- Reset, including mid-transaction:
  - state = IDLE, lock = 0, owner = 0, last_gnt = 1.
  - A pending read is dropped; its late s_rvalid_i is ignored.
- Reset output values: s_avalid_o = 0 unless an input avalid is high; mx_ready_o = 0; mx_rvalid_o = 0.

## Timing
- Zero added latency on the request path: mx_avalid_i -> s_avalid_o and s_ready_i -> mx_ready_o are combinational.
- Read response path: s_rvalid_i -> mx_rvalid_o is combinational through the registered owner.
- Read occupancy: from acceptance cycle A to the rvalid cycle R. The next request can issue at R+1 at the earliest.
- Writes: one write may be accepted every cycle, including alternating m0/m1 writes under round-robin.
- Simultaneous requests in IDLE with the lock clear resolve in the same cycle. No idle bubble.
- cke_i = 0: state, owner, lock and last_gnt hold. Combinational paths stay live.

## Configuration
- IOB_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. m1 (data) always wins when both requesters request; last_gnt is unused.
  - Undefined (default): round-robin as described in Operation.
- The lock and the single-outstanding-read rules apply in both modes.

## Test plan
- Reset, then m0 read at 0x100 with s_ready_i = 1 and rvalid two cycles later (rdata 0xDEADBEEF):
  - m0_ready_o pulses one cycle, then m0_rvalid_o pulses with 0xDEADBEEF.
  - m1_rvalid_o stays 0; state returns to IDLE.
- m0 and m1 request reads continuously from the same cycle after reset:
  - Grants alternate m0, m1, m0, m1.
  - Each next grant appears exactly one cycle after the previous rvalid.
  - With IOB_ARB_FIXED_PRIO_EN defined, only m1 is served while it requests.
- m1 write to 0x200, wstrb 0xF, with s_ready_i low for 3 cycles:
  - s_addr_o holds 0x200 for 4 cycles.
  - An m0 request arriving in cycle 2 is not granted until after acceptance.
- Back-to-back writes, m0 and m1 alternating every cycle with s_ready_i = 1:
  - One acceptance per cycle; state stays IDLE throughout.
- rst_i asserted in WAIT_RD, then s_rvalid_i arrives:
  - Both mx_rvalid_o stay 0.
  - A new m1 request is granted in the cycle after reset deasserts.
- cke_i = 0 for 5 cycles during WAIT_RD:
  - State and owner hold.
  - An s_rvalid_i in that window is still routed to the owner. Combinational output, state update deferred until cke_i returns high.
